fpga_reset_sequencer: RTL and testbench
=======================================

Name: fpga_reset_sequencer

Overview:
- Parametrised multi-channel FPGA internal reset generator. Holds NUM_CH active-low reset outputs asserted, waits INIT_DELAY cycles, then releases channels 0..NUM_CH-1 in ascending order, spaced STAGE_DELAY+1 cycles apart.
- Adds a synchronous soft-reset request that re-runs the whole sequence without an external reset.
- Sits between the board reset input and the FPGA core sub-blocks, e.g. clocking, register file, DSP interface, peripheral logic.

Parameters:
- NUM_CH, 4: number of reset channels; legal range 1..16.
- CNT_W, 16: delay counter width. INIT_DELAY and STAGE_DELAY must each be less than 2^CNT_W. The implementation checks this at elaboration.
- INIT_DELAY, 16'd4096: cycles counted after reset/soft-reset before channel 0 releases.
- STAGE_DELAY, 16'd1000: spacing between consecutive channel releases is STAGE_DELAY+1 cycles.

Ports:
- clk  input  1  timing clock for the delay counter
- rst  input  1  asynchronous, active-high reset; one clock domain only
- soft_rst_req  input  1  synchronous soft reset request, sampled on clk
- rst_out_n  output  NUM_CH  per-channel active-low reset; bit k feeds sub-block k
- seq_busy  output  1  high while the sequence is in progress
- seq_done  output  1  high once every channel is released

Behaviour:
- All outputs are registered.
- rst high (async): state=IDLE, cnt=0, idx=0, rst_out_n=all 0, seq_busy=0, seq_done=0. Outputs go low immediately, with no clock needed.
- States and transitions:
  - IDLE: all outputs held low, cnt=0.
    - soft_rst_req=0 -> INIT_WAIT, seq_busy=1.
    - soft_rst_req=1 -> stay in IDLE.
  - INIT_WAIT: cnt increments each cycle.
    - On the edge where cnt==INIT_DELAY: rst_out_n[0]<=1, cnt<=0, idx<=1.
    - Then go to RELEASE, or to DONE if NUM_CH==1.
  - RELEASE: cnt increments each cycle.
    - On the edge where cnt==STAGE_DELAY: rst_out_n[idx]<=1, cnt<=0, idx<=idx+1.
    - If idx==NUM_CH-1, go to DONE.
  - DONE: rst_out_n all 1, seq_done=1, seq_busy=0, cnt held at 0. Stays here until soft_rst_req or rst.
  - Illegal state encodings: recover to IDLE with all outputs low.
- Timing, measured from the first rising edge after rst deasserts (counted as edge 1):
  - rst_out_n[0] rises on edge INIT_DELAY+2.
  - rst_out_n[k] rises on edge INIT_DELAY+2+k*(STAGE_DELAY+1).
  - seq_done rises on the same edge as rst_out_n[NUM_CH-1]; seq_busy falls on that edge.
- Release order: a released channel never re-asserts except through rst or soft_rst_req. rst_out_n bits are monotonic during a sequence.
- soft_rst_req=1 sampled in any state (feature disabled):
  - Next edge: rst_out_n=all 0, seq_done=0, seq_busy=0, cnt=0, idx=0, state=IDLE.
  - Highest priority after rst; overrides a release due on the same edge.
- soft_rst_req held high keeps the block in IDLE. The sequence restarts with identical timing from the first edge on which it is sampled low.
- rst asserted mid-sequence: immediate return to the reset values; the full sequence reruns after deassertion.
- Counter arithmetic is CNT_W-bit unsigned and never wraps, because the compare precedes overflow.

Optional Feature:
- Macro: FPGA_RSTSEQ_REVERSE_ASSERT_EN
- Defined: soft_rst_req sampled in RELEASE or DONE enters SHUTDOWN.
  - seq_done<=0, seq_busy<=1.
  - On that edge, the highest released channel goes low.
  - Each further STAGE_DELAY+1 cycles, the next lower released channel goes low.
  - On the edge rst_out_n[0] goes low, go to IDLE with seq_busy<=0.
  - soft_rst_req is ignored during SHUTDOWN; rst still aborts it immediately.
  - In IDLE/INIT_WAIT, soft_rst_req behaves exactly as with the feature disabled.
- Undefined: SHUTDOWN does not exist; all channels assert together, as described under Behaviour.

Test Plan:
- NUM_CH=4, INIT_DELAY=10, STAGE_DELAY=5; release rst -> rst_out_n[0..3] rise on edges 12/18/24/30; seq_done rises on edge 30; seq_busy is high on edges 1-29 and low from edge 30.
- Same configuration; pulse soft_rst_req for 1 cycle in DONE (feature off) -> next edge rst_out_n=4'b0000, seq_done=0. Channel 0 rises 12 edges after the pulse edge, and the sequence repeats.
- Assert rst asynchronously between edges 20 and 21 -> rst_out_n=0 with no clock edge. After release, timing is identical to the first test.
- Hold soft_rst_req high for 50 cycles -> outputs stay 0 and seq_busy=0. After the drop, channels release on edges 12/18/24/30 relative to the first low sample.
- NUM_CH=1, INIT_DELAY=0 -> rst_out_n[0] and seq_done rise together on edge 2.
- Feature on, NUM_CH=4, STAGE_DELAY=5; soft_rst_req in DONE at edge T -> ch3 low at T, ch2 at T+6, ch1 at T+12, ch0 at T+18; IDLE, then re-release begins; a second request at T+3 has no effect.

Source files
------------

// File: rtl/fpga_reset_sequencer.sv
// Multi-channel reset sequencer: releases active-low resets in ascending order with programmable spacing.
// Optional macro FPGA_RSTSEQ_REVERSE_ASSERT_EN adds a SHUTDOWN state that re-asserts channels in reverse order.
module fpga_reset_sequencer #(
  parameter int unsigned NUM_CH      = 32'd4,
  parameter int unsigned CNT_W       = 32'd16,
  parameter int unsigned INIT_DELAY  = 32'd4096,
  parameter int unsigned STAGE_DELAY = 32'd1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst_req,
  output logic [NUM_CH-1:0] rst_out_n,
  output logic              seq_busy,
  output logic              seq_done
);

  localparam int unsigned IDX_W = $clog2(NUM_CH + 32'd1);
  localparam logic [CNT_W-1:0]  INIT_C   = CNT_W'(INIT_DELAY);
  localparam logic [CNT_W-1:0]  STAGE_C  = CNT_W'(STAGE_DELAY);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 32'd1);
  localparam logic [NUM_CH-1:0] ONE_CH   = NUM_CH'(32'd1);

  if ((NUM_CH < 32'd1) || (NUM_CH > 32'd16)) begin : g_bad_num_ch
    $error("fpga_reset_sequencer: NUM_CH must be in 1..16");
  end
  if ((64'(INIT_DELAY) >= (64'd1 << CNT_W)) || (64'(STAGE_DELAY) >= (64'd1 << CNT_W))) begin : g_bad_delay
    $error("fpga_reset_sequencer: INIT_DELAY and STAGE_DELAY must be below 2**CNT_W");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT_WAIT = 3'd1,
    RELEASE   = 3'd2,
`ifdef FPGA_RSTSEQ_REVERSE_ASSERT_EN
    SHUTDOWN  = 3'd4,
`endif
    DONE      = 3'd3
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic [NUM_CH-1:0] rel_r, rel_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              soft_ordered_s;

  // With reverse assertion, a request after the first release winds channels down instead of dropping them all.
`ifdef FPGA_RSTSEQ_REVERSE_ASSERT_EN
  assign soft_ordered_s = (state_r == RELEASE) || (state_r == DONE) || (state_r == SHUTDOWN);
`else
  assign soft_ordered_s = 1'b0;
`endif

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      rel_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      rel_r   <= rel_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state and next-output logic; soft request outranks any release due on the same edge.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    rel_s   = rel_r;
    busy_s  = busy_r;
    done_s  = done_r;
    if (soft_rst_req && !soft_ordered_s) begin
      state_s = IDLE;
      cnt_s   = '0;
      idx_s   = '0;
      rel_s   = '0;
      busy_s  = 1'b0;
      done_s  = 1'b0;
    end
`ifdef FPGA_RSTSEQ_REVERSE_ASSERT_EN
    else if (soft_rst_req && (state_r != SHUTDOWN)) begin
      // idx_r counts released channels, so the highest released one is idx_r-1.
      rel_s  = rel_r & ~(ONE_CH << (idx_r - IDX_W'(32'd1)));
      cnt_s  = '0;
      done_s = 1'b0;
      if (idx_r == IDX_W'(32'd1)) begin
        state_s = IDLE;
        idx_s   = '0;
        busy_s  = 1'b0;
      end else begin
        state_s = SHUTDOWN;
        idx_s   = idx_r - IDX_W'(32'd1);
        busy_s  = 1'b1;
      end
    end
`endif
    else begin
      case (state_r)
        IDLE: begin
          cnt_s   = '0;
          idx_s   = '0;
          rel_s   = '0;
          done_s  = 1'b0;
          busy_s  = 1'b1;
          state_s = INIT_WAIT;
        end
        INIT_WAIT: begin
          if (cnt_r == INIT_C) begin
            rel_s = rel_r | ONE_CH;
            cnt_s = '0;
            idx_s = IDX_W'(32'd1);
            if (NUM_CH == 32'd1) begin
              state_s = DONE;
              busy_s  = 1'b0;
              done_s  = 1'b1;
            end else begin
              state_s = RELEASE;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(32'd1);
          end
        end
        RELEASE: begin
          if (cnt_r == STAGE_C) begin
            rel_s = rel_r | (ONE_CH << idx_r);
            cnt_s = '0;
            idx_s = idx_r + IDX_W'(32'd1);
            if (idx_r == LAST_IDX) begin
              state_s = DONE;
              busy_s  = 1'b0;
              done_s  = 1'b1;
            end else begin
              state_s = RELEASE;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(32'd1);
          end
        end
        DONE: begin
          rel_s  = {NUM_CH{1'b1}};
          cnt_s  = '0;
          busy_s = 1'b0;
          done_s = 1'b1;
        end
`ifdef FPGA_RSTSEQ_REVERSE_ASSERT_EN
        SHUTDOWN: begin
          if (cnt_r == STAGE_C) begin
            rel_s = rel_r & ~(ONE_CH << (idx_r - IDX_W'(32'd1)));
            cnt_s = '0;
            idx_s = idx_r - IDX_W'(32'd1);
            if (idx_r == IDX_W'(32'd1)) begin
              state_s = IDLE;
              busy_s  = 1'b0;
            end else begin
              state_s = SHUTDOWN;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(32'd1);
          end
        end
`endif
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
          idx_s   = '0;
          rel_s   = '0;
          busy_s  = 1'b0;
          done_s  = 1'b0;
        end
      endcase
    end
  end

  assign rst_out_n = rel_r;
  assign seq_busy  = busy_r;
  assign seq_done  = done_r;

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Directed bench for fpga_reset_sequencer: 4-channel (10/5) instance plus a 1-channel zero-delay instance.
module tb_fpga_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       soft_rst_req;
  logic       soft1;
  logic [3:0] rst_out_n;
  logic       seq_busy, seq_done;
  logic [0:0] rst_out_n1;
  logic       seq_busy1, seq_done1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  fpga_reset_sequencer #(.NUM_CH(32'd4), .CNT_W(32'd16), .INIT_DELAY(32'd10), .STAGE_DELAY(32'd5)) dut (
    .clk(clk), .rst(rst), .soft_rst_req(soft_rst_req),
    .rst_out_n(rst_out_n), .seq_busy(seq_busy), .seq_done(seq_done)
  );

  fpga_reset_sequencer #(.NUM_CH(32'd1), .CNT_W(32'd8), .INIT_DELAY(32'd0), .STAGE_DELAY(32'd3)) dut1 (
    .clk(clk), .rst(rst), .soft_rst_req(soft1),
    .rst_out_n(rst_out_n1), .seq_busy(seq_busy1), .seq_done(seq_done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived release edges for INIT_DELAY=10, STAGE_DELAY=5: 12, 18, 24, 30.
  function automatic logic [3:0] exp_rel(input int e);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = (e >= 12 + 6 * k);
    return r;
  endfunction

  task automatic chk_seq(input string tag, input int e);
    chk($sformatf("%s_rel_e%0d", tag, e), {28'd0, rst_out_n}, {28'd0, exp_rel(e)});
    chk($sformatf("%s_busy_e%0d", tag, e), {31'd0, seq_busy}, {31'd0, (e >= 1 && e < 30)});
    chk($sformatf("%s_done_e%0d", tag, e), {31'd0, seq_done}, {31'd0, (e >= 30)});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rel"}, {28'd0, rst_out_n}, 32'd0);
    chk({tag, "_busy"}, {31'd0, seq_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, seq_done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    soft_rst_req = 1'b0;
    soft1 = 1'b0;
    #22;
    chk_zero("reset");
    chk("reset1_rel", {31'd0, rst_out_n1}, 32'd0);

    // Test 1: plain sequence, with the 1-channel instance checked on edges 1 and 2.
    step();
    rst = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      step();
      chk_seq("seq1", e);
      if (e <= 2) begin
        chk($sformatf("one_rel_e%0d", e), {31'd0, rst_out_n1}, {31'd0, (e == 2)});
        chk($sformatf("one_done_e%0d", e), {31'd0, seq_done1}, {31'd0, (e == 2)});
        chk($sformatf("one_busy_e%0d", e), {31'd0, seq_busy1}, {31'd0, (e == 1)});
      end
    end

`ifndef FPGA_RSTSEQ_REVERSE_ASSERT_EN
    // Test 2: one-cycle soft request in DONE drops everything, then the sequence repeats.
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    chk_zero("soft_pulse");
    for (int e = 1; e <= 30; e++) begin
      step();
      chk_seq("seq2", e);
    end
`endif

    // Test 3: asynchronous rst between edges 20 and 21.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step();
      chk_seq("pre_async", e);
    end
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    step();
    rst = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      step();
      chk_seq("seq3", e);
    end

    // Test 4: soft request held high for 50 cycles straight out of reset.
    rst = 1'b1;
    soft_rst_req = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      step();
      chk_zero($sformatf("soft_hold_c%0d", c));
    end
    soft_rst_req = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      step();
      chk_seq("seq4", e);
    end

`ifdef FPGA_RSTSEQ_REVERSE_ASSERT_EN
    // Test 5: reverse shutdown from DONE; the request at T+3 must be ignored.
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    chk("shut_rel_T", {28'd0, rst_out_n}, 32'h7);
    chk("shut_busy_T", {31'd0, seq_busy}, 32'd1);
    chk("shut_done_T", {31'd0, seq_done}, 32'd0);
    for (int d = 1; d <= 30; d++) begin
      logic [3:0] er;
      logic       eb;
      soft_rst_req = (d == 3);
      step();
      soft_rst_req = 1'b0;
      if (d < 6)       begin er = 4'b0111; eb = 1'b1; end
      else if (d < 12) begin er = 4'b0011; eb = 1'b1; end
      else if (d < 18) begin er = 4'b0001; eb = 1'b1; end
      else if (d == 18) begin er = 4'b0000; eb = 1'b0; end
      else begin er = exp_rel(d - 18); eb = 1'b1; end
      chk($sformatf("shut_rel_d%0d", d), {28'd0, rst_out_n}, {28'd0, er});
      chk($sformatf("shut_busy_d%0d", d), {31'd0, seq_busy}, {31'd0, eb});
      chk($sformatf("shut_done_d%0d", d), {31'd0, seq_done}, 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
